// File: rtl/dma_voice_pkg.sv
// Shared state encoding and voice-record layout for the DMA voice request FSM.
package dma_voice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INFO_REQ,
    ST_INFO_WAIT,
    ST_VOICE_CHECK,
    ST_STREAM_REQ,
    ST_STREAM_WAIT,
    ST_NEXT_VOICE
  } state_t;

  localparam int ADDR_WORD = 0;
  localparam int LEN_WORD  = 1;

  // Index widths never collapse to zero bits, even for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_voice_info_buf.sv
// Voice-info register file: bulk clear, one indexed write per cycle and a
// combinational read of the address/length words of one voice record.
module dma_voice_info_buf
  import dma_voice_pkg::*;
#(
  parameter int NUM_WORDS   = 16,
  parameter int STRUCT_SIZE = 4,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = 4,
  parameter int VOICE_W     = 2
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [DATA_W-1:0]  i_wr_data,
  input  logic [VOICE_W-1:0] i_voice,
  output logic [DATA_W-1:0]  o_word0,
  output logic [DATA_W-1:0]  o_word1
);

  logic [DATA_W-1:0] r_mem [NUM_WORDS];
  logic [IDX_W-1:0]  w_rec_base;

  assign w_rec_base = IDX_W'(i_voice) * IDX_W'(STRUCT_SIZE);
  assign o_word0    = r_mem[w_rec_base + IDX_W'(ADDR_WORD)];
  assign o_word1    = r_mem[w_rec_base + IDX_W'(LEN_WORD)];

  // Clear wins over write so a new pass always starts from an all-zero block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/dma_voice_req_fsm.sv
// Fetches a voice-info block, then issues one stream request per voice with a
// non-zero length and forwards the returned beats tagged with their voice.
module dma_voice_req_fsm
  import dma_voice_pkg::*;
#(
  parameter int VOICE_INFO_DMA_BURST_SIZE      = 16,
  parameter int VOICE_INFO_DATA_STRUCTURE_SIZE = 4,
  parameter int VOICE_STREAM_DMA_BURST_SIZE    = 64,
  parameter int C_M_AXI_ADDR_WIDTH             = 32,
  parameter int C_M_AXI_DATA_WIDTH             = 32,
  localparam int NUM_VOICES = VOICE_INFO_DMA_BURST_SIZE / VOICE_INFO_DATA_STRUCTURE_SIZE,
  localparam int VW         = clog2_min1(NUM_VOICES)
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_dma,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] dma_base_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] address,
  output logic                          dma_req,
  output logic [7:0]                    dma_req_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] dma_input_data,
  input  logic                          dma_input_data_valid,
  input  logic                          dma_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0] stream_data,
  output logic                          stream_data_valid,
  output logic [VW-1:0]                 stream_voice
);

  localparam int WAW = clog2_min1(VOICE_INFO_DMA_BURST_SIZE);
  localparam int IW  = $clog2(VOICE_INFO_DMA_BURST_SIZE + 1);

  state_t r_state;
  state_t w_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0] r_base;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_address;
  logic [7:0]                    r_req_len;
  logic                          r_req;
  logic [IW-1:0]                 r_index;
  logic [VW-1:0]                 r_voice;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_stream_data;
  logic                          r_stream_valid;
  logic [VW-1:0]                 r_stream_voice;

  logic                          w_pass_start;
  logic                          w_info_beat;
  logic                          w_stream_beat;
  logic                          w_last_voice;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_word0;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_word1;
  logic [7:0]                    w_stream_len;

  assign w_pass_start  = (r_state == ST_IDLE) && start_dma;
  assign w_info_beat   = (r_state == ST_INFO_WAIT) && dma_input_data_valid &&
                         (r_index < IW'(VOICE_INFO_DMA_BURST_SIZE));
  assign w_stream_beat = (r_state == ST_STREAM_WAIT) && dma_input_data_valid;
  assign w_last_voice  = (r_voice == VW'(NUM_VOICES - 1));

  dma_voice_info_buf #(
    .NUM_WORDS   (VOICE_INFO_DMA_BURST_SIZE),
    .STRUCT_SIZE (VOICE_INFO_DATA_STRUCTURE_SIZE),
    .DATA_W      (C_M_AXI_DATA_WIDTH),
    .IDX_W       (WAW),
    .VOICE_W     (VW)
  ) u_info_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_pass_start),
    .i_we      (w_info_beat),
    .i_wr_idx  (WAW'(r_index)),
    .i_wr_data (dma_input_data),
    .i_voice   (r_voice),
    .o_word0   (w_word0),
    .o_word1   (w_word1)
  );

  // A stream request never asks for more than one stream burst.
  always_comb begin
    w_stream_len = 8'(w_word1);
    if (w_word1 > C_M_AXI_DATA_WIDTH'(VOICE_STREAM_DMA_BURST_SIZE)) begin
      w_stream_len = 8'(VOICE_STREAM_DMA_BURST_SIZE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:        if (start_dma) w_next = ST_INFO_REQ;
      ST_INFO_REQ:    w_next = ST_INFO_WAIT;
      ST_INFO_WAIT:   if (dma_done) w_next = ST_VOICE_CHECK;
      ST_VOICE_CHECK: w_next = (w_word1 != '0) ? ST_STREAM_REQ : ST_NEXT_VOICE;
      ST_STREAM_REQ:  w_next = ST_STREAM_WAIT;
      ST_STREAM_WAIT: if (dma_done) w_next = ST_NEXT_VOICE;
      ST_NEXT_VOICE:  w_next = w_last_voice ? ST_IDLE : ST_VOICE_CHECK;
      default:        w_next = ST_IDLE;
    endcase
  end

  // Request address/length are captured at the request pulse and held until
  // the next request, so they stay valid through the whole transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base         <= '0;
      r_address      <= '0;
      r_req_len      <= '0;
      r_req          <= 1'b0;
      r_index        <= '0;
      r_voice        <= '0;
      r_stream_data  <= '0;
      r_stream_valid <= 1'b0;
      r_stream_voice <= '0;
    end else begin
      r_req          <= 1'b0;
      r_stream_valid <= w_stream_beat;
      if (w_pass_start) begin
        r_base  <= dma_base_addr;
        r_index <= '0;
      end
      if (r_state == ST_INFO_REQ) begin
        r_req     <= 1'b1;
        r_address <= r_base;
        r_req_len <= 8'(VOICE_INFO_DMA_BURST_SIZE);
      end
      if (r_state == ST_STREAM_REQ) begin
        r_req     <= 1'b1;
        r_address <= C_M_AXI_ADDR_WIDTH'(w_word0);
        r_req_len <= w_stream_len;
      end
      if (w_info_beat) begin
        r_index <= r_index + IW'(1);
      end
      if ((r_state == ST_INFO_WAIT) && dma_done) begin
        r_voice <= '0;
      end
      if ((r_state == ST_NEXT_VOICE) && !w_last_voice) begin
        r_voice <= r_voice + VW'(1);
      end
      if (w_stream_beat) begin
        r_stream_data  <= dma_input_data;
        r_stream_voice <= r_voice;
      end
    end
  end

  assign address           = r_address;
  assign dma_req           = r_req;
  assign dma_req_len       = r_req_len;
  assign stream_data       = r_stream_data;
  assign stream_data_valid = r_stream_valid;
  assign stream_voice      = r_stream_voice;

endmodule

// File: tb/tb_dma_voice_req_fsm.sv
// Randomized bench for dma_voice_req_fsm: a DMA responder plus a reference model
// that derives the expected request list and stream beats from the info block.
module tb_dma_voice_req_fsm;

  localparam int BURST  = 16;
  localparam int STRUCT = 4;
  localparam int SBURST = 64;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int NV     = BURST / STRUCT;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_dma;
  logic [AW-1:0] dma_base_addr;
  logic [AW-1:0] address;
  logic          dma_req;
  logic [7:0]    dma_req_len;
  logic [DW-1:0] dma_input_data;
  logic          dma_input_data_valid;
  logic          dma_done;
  logic [DW-1:0] stream_data;
  logic          stream_data_valid;
  logic [1:0]    stream_voice;

  always #5 clk = ~clk;

  dma_voice_req_fsm #(
    .VOICE_INFO_DMA_BURST_SIZE      (BURST),
    .VOICE_INFO_DATA_STRUCTURE_SIZE (STRUCT),
    .VOICE_STREAM_DMA_BURST_SIZE    (SBURST),
    .C_M_AXI_ADDR_WIDTH             (AW),
    .C_M_AXI_DATA_WIDTH             (DW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start_dma            (start_dma),
    .dma_base_addr        (dma_base_addr),
    .address              (address),
    .dma_req              (dma_req),
    .dma_req_len          (dma_req_len),
    .dma_input_data       (dma_input_data),
    .dma_input_data_valid (dma_input_data_valid),
    .dma_done             (dma_done),
    .stream_data          (stream_data),
    .stream_data_valid    (stream_data_valid),
    .stream_voice         (stream_voice)
  );

  int            checkCount = 0;
  int            failCount  = 0;
  int            reqPulses  = 0;
  int            respVoice  = -1;
  logic [DW-1:0] infoBeats[$];
  logic [DW-1:0] respQ[$];
  logic [DW-1:0] expData[$];
  int            expVoice[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Counts request pulses and scores every forwarded stream beat in order.
  always @(negedge clk) begin
    if (dma_req === 1'b1) reqPulses++;
    if (stream_data_valid === 1'b1) begin
      if (expData.size() == 0) begin
        checkOutput("streamUnexpected", 64'(1), 64'(0));
      end else begin
        checkOutput("streamData", 64'(stream_data), 64'(expData.pop_front()));
        checkOutput("streamVoice", 64'(stream_voice), 64'(expVoice.pop_front()));
      end
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitReq(input string tag, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dma_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({tag, "Timeout"}, 64'(0), 64'(1));
    #1;
  endtask

  // Plays respQ back as data beats; stopAfter >= 0 abandons the transfer early.
  task automatic respond(input bit doneWithLast, input bit gaps, input int stopAfter);
    int n;
    n = respQ.size();
    for (int k = 0; k < n; k++) begin
      if (k == stopAfter) return;
      if (gaps) while ($urandom_range(3) == 0) nextCycle();
      dma_input_data       = respQ[k];
      dma_input_data_valid = 1'b1;
      dma_done             = doneWithLast && (k == n - 1);
      if (respVoice >= 0) begin
        expData.push_back(respQ[k]);
        expVoice.push_back(respVoice);
      end
      nextCycle();
      dma_input_data_valid = 1'b0;
      dma_done             = 1'b0;
    end
    if (!(doneWithLast && n > 0)) begin
      dma_done = 1'b1;
      nextCycle();
      dma_done = 1'b0;
    end
  endtask

  // One full pass: the model turns the info block into the expected request list.
  task automatic applyStimulus(input logic [AW-1:0] base, input bit directed, input bit doneWithLast,
                               input bit gaps, input int abortVoice);
    logic [DW-1:0] info [BURST];
    logic [AW-1:0] eAddr[$];
    int            eLen[$];
    int            eVoice[$];
    int            startPulses;
    bit            seen;
    for (int i = 0; i < BURST; i++) info[i] = '0;
    for (int k = 0; k < infoBeats.size() && k < BURST; k++) info[k] = infoBeats[k];
    for (int v = 0; v < NV; v++) begin
      if (info[v*STRUCT + 1] != '0) begin
        eAddr.push_back(AW'(info[v*STRUCT]));
        eLen.push_back((info[v*STRUCT + 1] > DW'(SBURST)) ? SBURST : int'(info[v*STRUCT + 1]));
        eVoice.push_back(v);
      end
    end

    startPulses   = reqPulses;
    dma_base_addr = base;
    start_dma     = 1'b1;
    waitReq("infoReq", seen);
    start_dma = 1'b0;
    if (!seen) return;
    checkOutput("infoAddr", 64'(address), 64'(base));
    checkOutput("infoLen", 64'(dma_req_len), 64'(BURST));
    checkOutput("infoReqCount", 64'(reqPulses - startPulses), 64'(1));
    respQ     = infoBeats;
    respVoice = -1;
    respond(doneWithLast, gaps, -1);

    for (int r = 0; r < eAddr.size(); r++) begin
      waitReq("streamReq", seen);
      if (!seen) return;
      checkOutput("streamAddr", 64'(address), 64'(eAddr[r]));
      checkOutput("streamLen", 64'(dma_req_len), 64'(eLen[r]));
      checkOutput("streamReqCount", 64'(reqPulses - startPulses), 64'(r + 2));
      respQ.delete();
      for (int k = 0; k < eLen[r]; k++) respQ.push_back(directed ? DW'(16 * (k + 1)) : DW'($urandom));
      respVoice = eVoice[r];
      if (eVoice[r] == abortVoice) begin
        respond(1'b0, gaps, 5);
        return;
      end
      respond(doneWithLast, gaps, -1);
    end

    repeat (20) nextCycle();
    checkOutput("reqTotal", 64'(reqPulses - startPulses), 64'(eAddr.size() + 1));
    checkOutput("streamDrained", 64'(expData.size()), 64'(0));
  endtask

  function automatic logic [DW-1:0] pickLen();
    case ($urandom_range(7))
      0:       return '0;
      1:       return DW'(1);
      2:       return DW'(63);
      3:       return DW'(64);
      4:       return DW'(65);
      5:       return DW'($urandom_range(200, 1));
      6:       return DW'($urandom);
      default: return DW'(256);
    endcase
  endfunction

  // Info blocks may be short (unreceived words stay zero) or overlong (dropped).
  task automatic makeRandomInfo();
    int sel;
    int n;
    sel = $urandom_range(9);
    n   = (sel == 0) ? 12 : (sel == 1) ? 19 : BURST;
    infoBeats.delete();
    for (int k = 0; k < n; k++) begin
      if ((k % STRUCT) == 0)      infoBeats.push_back(DW'($urandom) & ~DW'(3));
      else if ((k % STRUCT) == 1) infoBeats.push_back(pickLen());
      else                        infoBeats.push_back(DW'($urandom));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Addr"}, 64'(address), 64'(0));
    checkOutput({tag, "Len"}, 64'(dma_req_len), 64'(0));
    checkOutput({tag, "Req"}, 64'(dma_req), 64'(0));
    checkOutput({tag, "Data"}, 64'(stream_data), 64'(0));
    checkOutput({tag, "Valid"}, 64'(stream_data_valid), 64'(0));
    checkOutput({tag, "Voice"}, 64'(stream_voice), 64'(0));
  endtask

  initial begin
    int  stray;
    int  startPulses;
    bit  seen;
    reset                = 1'b1;
    start_dma            = 1'b0;
    dma_base_addr        = '0;
    dma_input_data       = '0;
    dma_input_data_valid = 1'b0;
    dma_done             = 1'b0;
    repeat (3) nextCycle();
    checkAllZero("reset");
    reset = 1'b0;
    nextCycle();

    $display("[TB] directed pass, base 0");
    infoBeats.delete();
    for (int k = 0; k < BURST; k++) infoBeats.push_back(DW'(16 * (k + 1)));
    applyStimulus('0, 1'b1, 1'b0, 1'b0, -1);

    $display("[TB] all-zero info with start held high");
    infoBeats.delete();
    for (int k = 0; k < BURST; k++) infoBeats.push_back('0);
    startPulses   = reqPulses;
    dma_base_addr = AW'(32'h1000);
    start_dma     = 1'b1;
    waitReq("zeroReqA", seen);
    checkOutput("zeroAddrA", 64'(address), 64'(32'h1000));
    checkOutput("zeroLenA", 64'(dma_req_len), 64'(BURST));
    dma_base_addr = AW'(32'h2000);
    respQ     = infoBeats;
    respVoice = -1;
    respond(1'b0, 1'b0, -1);
    waitReq("zeroReqB", seen);
    start_dma = 1'b0;
    checkOutput("zeroAddrB", 64'(address), 64'(32'h2000));
    checkOutput("zeroLenB", 64'(dma_req_len), 64'(BURST));
    respond(1'b1, 1'b0, -1);
    repeat (20) nextCycle();
    checkOutput("zeroReqTotal", 64'(reqPulses - startPulses), 64'(2));

    $display("[TB] reset during voice 2 stream");
    infoBeats.delete();
    for (int k = 0; k < BURST; k++) infoBeats.push_back(DW'(16 * (k + 1)));
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 2);
    #3 reset = 1'b1;
    #1 checkAllZero("midReset");
    expData.delete();
    expVoice.delete();
    nextCycle();
    reset                = 1'b0;
    stray                = 0;
    dma_done             = 1'b1;
    dma_input_data_valid = 1'b1;
    dma_input_data       = DW'(32'hDEAD);
    repeat (4) begin
      nextCycle();
      if (dma_req || stream_data_valid) stray++;
    end
    dma_done             = 1'b0;
    dma_input_data_valid = 1'b0;
    checkOutput("strayIgnored", 64'(stray), 64'(0));
    applyStimulus('0, 1'b1, 1'b0, 1'b0, -1);

    $display("[TB] randomized passes");
    for (int p = 0; p < 8; p++) begin
      makeRandomInfo();
      applyStimulus(AW'($urandom) & ~AW'(3), 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/dma_voice_req_fsm.md
DMA_VOICE_REQ_FSM -- requirements
Module: dma_voice_req_fsm

Interface
REQ-001 Parameter VOICE_INFO_DMA_BURST_SIZE, default 16: words fetched per voice-info block.
REQ-002 Parameter VOICE_INFO_DATA_STRUCTURE_SIZE, default 4: words per voice record; NUM_VOICES = BURST/STRUCT (default 4).
REQ-003 Parameter VOICE_STREAM_DMA_BURST_SIZE, default 64: maximum words per stream request.
REQ-004 Parameters C_M_AXI_ADDR_WIDTH and C_M_AXI_DATA_WIDTH, default 32 each: address and data widths.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start_dma  in  1  level; starts a pass when sampled high in IDLE.
REQ-009 dma_base_addr  in  ADDR  byte address of the voice-info block; latched at pass start.
REQ-010 address  out  ADDR  request byte address; stable from the request pulse until dma_done.
REQ-011 dma_req  out  1  one-cycle request pulse.
REQ-012 dma_req_len  out  8  number of data beats requested (beat count, not AXI len-1); stable with address.
REQ-013 dma_input_data  in  DATA  returned beat.
REQ-014 dma_input_data_valid  in  1  beat qualifier.
REQ-015 dma_done  in  1  one-cycle pulse; ends the outstanding request.
REQ-016 stream_data  out  DATA  forwarded stream beat.
REQ-017 stream_data_valid  out  1  stream beat qualifier.
REQ-018 stream_voice  out  clog2(NUM_VOICES)  voice index of the forwarded beat.

Function
REQ-019 States: IDLE, INFO_REQ, INFO_WAIT, VOICE_CHECK, STREAM_REQ, STREAM_WAIT, NEXT_VOICE.
REQ-020 IDLE: start_dma=1 -> latch dma_base_addr, clear all info words to 0, go to INFO_REQ.
REQ-021 INFO_REQ (1 cycle): dma_req=1, address=latched base, dma_req_len=VOICE_INFO_DMA_BURST_SIZE; go to INFO_WAIT.
REQ-022 INFO_WAIT: each valid beat stores into info word[idx] and idx increments; beats beyond BURST-1 are dropped (idx saturates).
REQ-023 INFO_WAIT: dma_done -> voice=0, go to VOICE_CHECK; unreceived words remain 0.
REQ-024 Voice record v occupies words v*STRUCT+0..3: word0 = stream byte address, word1 = remaining length in words, words 2-3 reserved.
REQ-025 VOICE_CHECK: word1 != 0 -> STREAM_REQ; otherwise -> NEXT_VOICE.
REQ-026 STREAM_REQ (1 cycle): dma_req=1, address=word0, dma_req_len=min(word1, VOICE_STREAM_DMA_BURST_SIZE) truncated to 8 bits; go to STREAM_WAIT.
REQ-027 STREAM_WAIT: each valid beat -> stream_data=dma_input_data, stream_data_valid=1 and stream_voice=voice, all registered one cycle after the input; dma_done -> NEXT_VOICE.
REQ-028 NEXT_VOICE: last voice -> IDLE; otherwise voice+1 -> VOICE_CHECK.
REQ-029 A pass always completes; start_dma still high in IDLE starts a new pass, with the first dma_req one cycle after entering INFO_REQ.
REQ-030 dma_input_data_valid and dma_done outside the WAIT states are ignored.
REQ-031 Only one request is outstanding at a time; dma_req never re-asserts before dma_done.
REQ-032 dma_done and a final valid beat in the same cycle: the beat is accepted, then the state transitions.

Reset
REQ-033 Reset forces IDLE and clears address, dma_req_len, dma_req, stream outputs, info words, index and voice to 0 immediately.
REQ-034 Reset mid-request abandons the request; later dma_done or valid beats are ignored.

Structure
REQ-035 Package dma_voice_pkg holds the state enum and the record word-offset constants (ADDR_WORD=0, LEN_WORD=1).
REQ-036 Sub-module dma_voice_info_buf holds the info word register file: clear input, indexed write, per-voice word0/word1 read.

Verification
REQ-037 Bench responder: on dma_req, returns dma_req_len beats 0x10, 0x20, ..., then pulses dma_done.
REQ-038 Reset, then start_dma=1 with base 0 -> dma_req with address 0x0 and len 16; info words become 0x10..0x100.
REQ-039 Same run -> stream requests (0x10, 32), (0x50, 64), (0x90, 64), (0xD0, 64) in that order, each after the prior dma_done.
REQ-040 Voice 0 stream -> 32 stream_data_valid beats with stream_voice=0 and data 0x10..0x200.
REQ-041 Info block returning all zeros -> no stream requests; FSM returns to IDLE.
REQ-042 Reset asserted during voice-2 STREAM_WAIT -> all outputs 0 next edge; a new pass starts from INFO_REQ.
